// File: rtl/cpu_pkg.sv
// Shared CPU constants and packed-port helpers used by the register file slice.
package cpu_pkg;

    localparam int unsigned REG_DATA_WIDTH = 32;
    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam int unsigned REG_ZERO       = 0;

    // Bit offset of packed port i when each port is width bits wide.
    function automatic int unsigned field(input int unsigned i, input int unsigned width);
        return i * width;
    endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Register file bus: one write port, NUM_RD packed read ports, scoreboard control.
interface reg_file_sb_if #(
    parameter int unsigned DATA_WIDTH = cpu_pkg::REG_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = cpu_pkg::REG_ADDR_WIDTH,
    parameter int unsigned NUM_RD     = 2
);
    logic                           wen;
    logic [ADDR_WIDTH-1:0]          waddr;
    logic [DATA_WIDTH-1:0]          wdata;
    logic [NUM_RD*ADDR_WIDTH-1:0]   raddr;
    logic [NUM_RD*DATA_WIDTH-1:0]   rdata;
    logic [NUM_RD-1:0]              rbusy;
    logic                           busy_set;
    logic [ADDR_WIDTH-1:0]          busy_addr;
    logic                           flush;
    logic [(1 << ADDR_WIDTH)-1:0]   busy_vec;

    modport master (
        output wen, waddr, wdata, raddr, busy_set, busy_addr, flush,
        input  rdata, rbusy, busy_vec
    );

    modport slave (
        input  wen, waddr, wdata, raddr, busy_set, busy_addr, flush,
        output rdata, rbusy, busy_vec
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, bit 0 always clear,
// plus a raw per-read-port lookup of the addressed bit.
module reg_scoreboard
    import cpu_pkg::*;
#(
    parameter  int unsigned ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter  int unsigned NUM_RD     = 2,
    localparam int unsigned DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         wen,
    input  logic [ADDR_WIDTH-1:0]        waddr,
    input  logic                         busy_set,
    input  logic [ADDR_WIDTH-1:0]        busy_addr,
    input  logic                         flush,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_RD-1:0]            rd_busy,
    output logic [DEPTH-1:0]             busy_vec
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Retire/flush first, then issue, so a same-edge issue always survives.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else if (wen) begin
            busy_d[waddr] = 1'b0;
        end
        if (busy_set && (busy_addr != ADDR_WIDTH'(REG_ZERO))) begin
            busy_d[busy_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_lookup
        assign rd_busy[g] = busy_q[raddr[field(g, ADDR_WIDTH) +: ADDR_WIDTH]];
    end

endmodule

// File: rtl/reg_file_sb.sv
// General-purpose register file with zero register, write-through bypass and
// an integrated pending-write scoreboard for decode hazard detection.
module reg_file_sb
    import cpu_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = REG_DATA_WIDTH,
    parameter  int unsigned ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter  int unsigned NUM_RD     = 2,
    parameter  int unsigned BYPASS     = 1,
    localparam int unsigned DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic         clk,
    input  logic         rstn,
    reg_file_sb_if.slave bus
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [NUM_RD-1:0]     sb_busy;

    reg_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_RD     (NUM_RD)
    ) u_sb (
        .clk       (clk),
        .rstn      (rstn),
        .wen       (bus.wen),
        .waddr     (bus.waddr),
        .busy_set  (bus.busy_set),
        .busy_addr (bus.busy_addr),
        .flush     (bus.flush),
        .raddr     (bus.raddr),
        .rd_busy   (sb_busy),
        .busy_vec  (bus.busy_vec)
    );

    // Storage; entry 0 is never written so it stays at its reset value of 0.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[ADDR_WIDTH'(i)] <= '0;
            end
        end else if (bus.wen && (bus.waddr != ADDR_WIDTH'(REG_ZERO))) begin
            mem[bus.waddr] <= bus.wdata;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic                  is_zero;
        logic                  hit;

        assign ra      = bus.raddr[field(g, ADDR_WIDTH) +: ADDR_WIDTH];
        assign is_zero = (ra == ADDR_WIDTH'(REG_ZERO));
        // A forwarded write-back also hides the producer's busy bit.
        assign hit     = (BYPASS != 0) && bus.wen && (bus.waddr == ra);

        assign bus.rdata[field(g, DATA_WIDTH) +: DATA_WIDTH] =
            (!rstn || is_zero) ? '0 :
            hit                ? bus.wdata :
                                 mem[ra];

        assign bus.rbusy[g] = rstn && !is_zero && sb_busy[g] && !hit;
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: bypass and non-bypass instances share stimulus against a
// reference model; a third 3-port/64-entry instance is checked with literals.
module tb_reg_file_sb;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    reg_file_sb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2)) ifa ();
    reg_file_sb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2)) ifb ();
    reg_file_sb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .NUM_RD(3)) ifc ();

    reg_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .BYPASS(1))
        dut_a (.clk(clk), .rstn(rstn), .bus(ifa));
    reg_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .BYPASS(0))
        dut_b (.clk(clk), .rstn(rstn), .bus(ifb));
    reg_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .NUM_RD(3), .BYPASS(1))
        dut_c (.clk(clk), .rstn(rstn), .bus(ifc));

    assign ifb.wen       = ifa.wen;
    assign ifb.waddr     = ifa.waddr;
    assign ifb.wdata     = ifa.wdata;
    assign ifb.raddr     = ifa.raddr;
    assign ifb.busy_set  = ifa.busy_set;
    assign ifb.busy_addr = ifa.busy_addr;
    assign ifb.flush     = ifa.flush;

    int total  = 0;
    int passed = 0;
    bit chk_en = 1'b0;

    logic [31:0] ref_mem [32];
    logic [31:0] ref_busy;
    logic [31:0] nb;
    logic [4:0]  ra;
    logic [63:0] tmp64;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: architectural register and pending-producer state.
    always @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
            ref_busy = 32'h0;
        end else begin
            if (ifa.wen && ifa.waddr != 5'd0) ref_mem[ifa.waddr] = ifa.wdata;
            nb = ref_busy;
            if (ifa.flush) nb = 32'h0;
            else if (ifa.wen) nb[ifa.waddr] = 1'b0;
            if (ifa.busy_set && ifa.busy_addr != 5'd0) nb[ifa.busy_addr] = 1'b1;
            ref_busy = nb;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (!rstn || a == 5'd0) return 32'h0;
        if (byp && ifa.wen && ifa.waddr == a) return ifa.wdata;
        return ref_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a, input bit byp);
        if (!rstn || a == 5'd0) return 1'b0;
        return ref_busy[a] && !(byp && ifa.wen && ifa.waddr == a);
    endfunction

    // Every-cycle comparison of both 32-entry instances against the model.
    always begin
        @(negedge clk);
        #3;
        if (chk_en) begin
            for (int p = 0; p < 2; p++) begin
                ra = ifa.raddr[p*5 +: 5];
                check("a_rdata", 64'(ifa.rdata[p*32 +: 32]), 64'(exp_rd(ra, 1'b1)));
                check("a_rbusy", 64'(ifa.rbusy[p]),          64'(exp_busy(ra, 1'b1)));
                check("b_rdata", 64'(ifb.rdata[p*32 +: 32]), 64'(exp_rd(ra, 1'b0)));
                check("b_rbusy", 64'(ifb.rbusy[p]),          64'(exp_busy(ra, 1'b0)));
            end
            check("a_busy_vec", 64'(ifa.busy_vec), 64'(ref_busy));
            check("b_busy_vec", 64'(ifb.busy_vec), 64'(ref_busy));
        end
    end

    task automatic idle();
        ifa.wen = 1'b0; ifa.waddr = 5'd0; ifa.wdata = 32'h0; ifa.raddr = 10'h0;
        ifa.busy_set = 1'b0; ifa.busy_addr = 5'd0; ifa.flush = 1'b0;
    endtask

    task automatic idle_c();
        ifc.wen = 1'b0; ifc.waddr = 6'd0; ifc.wdata = 32'h0; ifc.raddr = 18'h0;
        ifc.busy_set = 1'b0; ifc.busy_addr = 6'd0; ifc.flush = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        idle();
        idle_c();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn   = 1'b1;
        chk_en = 1'b1;

        // Fill every entry and mark every register pending.
        for (int i = 1; i < 32; i++) begin
            ifa.wen = 1'b1; ifa.waddr = 5'(i); ifa.wdata = 32'hFFFF_FFFF;
            ifa.busy_set = 1'b1; ifa.busy_addr = 5'(i);
            ifa.raddr = {5'(i), 5'(i - 1)};
            @(negedge clk);
        end
        idle();
        #4 check("preload_busy_vec", 64'(ifa.busy_vec), 64'h0000_0000_FFFF_FFFE);

        // One reset cycle competing with a write, an issue and a bypass read.
        @(negedge clk);
        rstn = 1'b0;
        ifa.wen = 1'b1; ifa.waddr = 5'd31; ifa.wdata = 32'h1234;
        ifa.busy_set = 1'b1; ifa.busy_addr = 5'd31; ifa.raddr = {5'd31, 5'd5};
        #4;
        check("rst_rdata0", 64'(ifa.rdata[31:0]),  64'h0);
        check("rst_rdata1", 64'(ifa.rdata[63:32]), 64'h0);
        check("rst_rbusy",  64'(ifa.rbusy),        64'h0);
        @(negedge clk);
        rstn = 1'b1;
        idle();
        #4 check("post_rst_busy_vec", 64'(ifa.busy_vec), 64'h0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            ifa.raddr = {5'(i + 16), 5'(i)};
            #4;
            check("post_rst_rd0", 64'(ifa.rdata[31:0]),  64'h0);
            check("post_rst_rd1", 64'(ifa.rdata[63:32]), 64'h0);
        end

        // Writes to register 0 are dropped and never forwarded.
        @(negedge clk);
        idle();
        ifa.wen = 1'b1; ifa.waddr = 5'd0; ifa.wdata = 32'h1234_5678;
        #4 check("zero_same_cycle", 64'(ifa.rdata[63:32]), 64'h0);
        @(negedge clk);
        idle();
        #4;
        check("zero_next_a", 64'(ifa.rdata[31:0]), 64'h0);
        check("zero_next_b", 64'(ifb.rdata[31:0]), 64'h0);

        // Forwarding versus write-then-read.
        @(negedge clk);
        ifa.wen = 1'b1; ifa.waddr = 5'd7; ifa.wdata = 32'hDEAD_BEEF; ifa.raddr = {5'd0, 5'd7};
        #4;
        check("bypass_a", 64'(ifa.rdata[31:0]), 64'hDEAD_BEEF);
        check("nobypass_b_old", 64'(ifb.rdata[31:0]), 64'h0);
        @(negedge clk);
        idle();
        ifa.raddr = {5'd0, 5'd7};
        #4 check("nobypass_b_new", 64'(ifb.rdata[31:0]), 64'hDEAD_BEEF);

        // Producer for r5 issued at t, retires at t+3.
        @(negedge clk);
        ifa.busy_set = 1'b1; ifa.busy_addr = 5'd5; ifa.raddr = {5'd0, 5'd5};
        #4 check("sb_t_rbusy", 64'(ifa.rbusy[0]), 64'h0);
        @(negedge clk);
        idle();
        ifa.raddr = {5'd0, 5'd5};
        #4 check("sb_t1_rbusy", 64'(ifa.rbusy[0]), 64'h1);
        @(negedge clk);
        @(negedge clk);
        ifa.wen = 1'b1; ifa.waddr = 5'd5; ifa.wdata = 32'h55;
        #4;
        check("sb_t3_rbusy_a", 64'(ifa.rbusy[0]),      64'h0);
        check("sb_t3_rbusy_b", 64'(ifb.rbusy[0]),      64'h1);
        check("sb_t3_rdata_a", 64'(ifa.rdata[31:0]),   64'h55);
        check("sb_t3_rdata_b", 64'(ifb.rdata[31:0]),   64'h0);
        @(negedge clk);
        idle();
        ifa.raddr = {5'd0, 5'd5};
        #4;
        check("sb_t4_busy5", 64'(ifa.busy_vec[5]),   64'h0);
        check("sb_t4_rdata_b", 64'(ifb.rdata[31:0]), 64'h55);

        // Retire and issue of r9 on the same edge: issue wins, data still lands.
        @(negedge clk);
        ifa.wen = 1'b1; ifa.waddr = 5'd9; ifa.wdata = 32'h99;
        ifa.busy_set = 1'b1; ifa.busy_addr = 5'd9;
        @(negedge clk);
        idle();
        ifa.raddr = {5'd0, 5'd9};
        #4;
        check("coll_busy9", 64'(ifa.busy_vec[9]),   64'h1);
        check("coll_rdata", 64'(ifa.rdata[31:0]),   64'h99);
        check("coll_rbusy", 64'(ifa.rbusy[0]),      64'h1);

        // Flush with a same-edge issue keeps only the new producer.
        @(negedge clk);
        ifa.busy_set = 1'b1; ifa.busy_addr = 5'd4;
        @(negedge clk);
        ifa.busy_addr = 5'd6;
        @(negedge clk);
        ifa.flush = 1'b1; ifa.busy_addr = 5'd3;
        #4 check("pre_flush_vec", 64'(ifa.busy_vec), 64'h250);
        @(negedge clk);
        idle();
        #4 check("flush_vec", 64'(ifa.busy_vec), 64'h8);

        // Issue to r0 is ignored; retire and issue on different registers both apply.
        @(negedge clk);
        ifa.busy_set = 1'b1; ifa.busy_addr = 5'd0;
        @(negedge clk);
        idle();
        #4 check("set0_ignored", 64'(ifa.busy_vec), 64'h8);
        @(negedge clk);
        ifa.wen = 1'b1; ifa.waddr = 5'd3; ifa.wdata = 32'h33;
        ifa.busy_set = 1'b1; ifa.busy_addr = 5'd12;
        @(negedge clk);
        idle();
        #4 check("set_clr_diff", 64'(ifa.busy_vec), 64'h1000);
        @(negedge clk);
        ifa.flush = 1'b1;
        @(negedge clk);
        idle();
        #4 check("flush_only", 64'(ifa.busy_vec), 64'h0);

        // Three-port, 64-entry instance through the packed buses.
        check("c_reset_vec", ifc.busy_vec, 64'h0);
        @(negedge clk);
        ifc.wen = 1'b1; ifc.waddr = 6'd40; ifc.wdata = 32'hA0A0_0040;
        @(negedge clk);
        ifc.waddr = 6'd41; ifc.wdata = 32'h4141_4141;
        @(negedge clk);
        ifc.waddr = 6'd63; ifc.wdata = 32'h6363_6363;
        @(negedge clk);
        idle_c();
        ifc.raddr = {6'd63, 6'd41, 6'd40};
        #4;
        check("c_port0", 64'(ifc.rdata[31:0]),  64'hA0A0_0040);
        check("c_port1", 64'(ifc.rdata[63:32]), 64'h4141_4141);
        check("c_port2", 64'(ifc.rdata[95:64]), 64'h6363_6363);
        @(negedge clk);
        ifc.wen = 1'b1; ifc.waddr = 6'd63; ifc.wdata = 32'h0BAD_F00D;
        ifc.busy_set = 1'b1; ifc.busy_addr = 6'd41;
        #4;
        check("c_bypass2", 64'(ifc.rdata[95:64]), 64'h0BAD_F00D);
        check("c_rbusy_pre", 64'(ifc.rbusy),      64'h0);
        @(negedge clk);
        ifc.wen = 1'b0; ifc.busy_set = 1'b0;
        #4;
        tmp64 = 64'h1 << 41;
        check("c_rbusy_post", 64'(ifc.rbusy),      64'h2);
        check("c_busy_vec",   ifc.busy_vec,        tmp64);
        check("c_port2_new",  64'(ifc.rdata[95:64]), 64'h0BAD_F00D);
        check("c_port0_keep", 64'(ifc.rdata[31:0]),   64'hA0A0_0040);

        @(negedge clk);
        idle_c();
        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        #4;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
